// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and key-schedule shift tables for the DES round sequencer
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } des_ctrl_state_e;

    // Encrypt rotates left before each round; decrypt rotates right after an implicit
    // no-shift first round, so the C/D registers retrace the encrypt key order backwards.
    localparam logic [1:0] SHIFT_ENC [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] SHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_shift_sched.sv
// rtl/des_shift_sched.sv - per-round C/D rotate amount lookup
module des_shift_sched
    import des_pkg::*;
(
    input  logic [3:0] round,
    input  logic       mode,
    output logic [1:0] amt
);

    always_comb begin
        amt = mode ? SHIFT_DEC[round] : SHIFT_ENC[round];
    end

endmodule

// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - sequencer driving the shared f(R,K) datapath through all DES rounds
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS,
    parameter int ROUND_LAT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_decrypt,
    input  logic       abort,
    output logic       ld_en,
    output logic       ks_en,
    output logic       ks_dir,
    output logic [1:0] ks_amt,
    output logic       rnd_en,
    output logic [3:0] round,
    output logic       fp_en,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int             LW        = $clog2(ROUND_LAT + 1);
    localparam logic [LW-1:0]  LAT_LAST  = LW'(ROUND_LAT - 1);
    localparam logic [3:0]     RND_LAST  = 4'(NUM_ROUNDS - 1);

    des_ctrl_state_e state;
    logic [3:0]      round_q;
    logic [LW-1:0]   lat_cnt;
    logic            mode_q;

    logic            in_round;
    logic            lat_last;
    logic            rnd_last;
    logic [1:0]      tbl_amt;

    des_shift_sched u_shift_sched (
        .round (round_q),
        .mode  (mode_q),
        .amt   (tbl_amt)
    );

    assign in_round = (state == ROUND);
    assign lat_last = (lat_cnt == LAT_LAST);
    assign rnd_last = (round_q == RND_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            round_q <= 4'd0;
            lat_cnt <= '0;
            mode_q  <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            round_q <= 4'd0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= ROUND;
                        round_q <= 4'd0;
                        lat_cnt <= '0;
                        mode_q  <= in_decrypt;
                    end
                end
                ROUND: begin
                    if (lat_last) begin
                        lat_cnt <= '0;
                        if (rnd_last) begin
                            state <= FINAL;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                FINAL: begin
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        round_q <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath strobes are decoded from the registered state; abort suppresses any commit
    // in its own cycle so a cancelled block never touches L/R or the output register.
    always_comb begin
        in_ready  = (state == IDLE);
        ld_en     = (state == IDLE) && in_valid && !abort && !reset;
        ks_en     = in_round && (lat_cnt == '0);
        ks_amt    = ks_en ? tbl_amt : 2'd0;
        ks_dir    = in_round && mode_q;
        rnd_en    = in_round && lat_last && !abort;
        round     = round_q;
        fp_en     = (state == FINAL) && !abort;
        busy      = in_round || (state == FINAL);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb/tb_des_round_ctrl.sv - randomized self-checking bench for des_round_ctrl at ROUND_LAT 2 and 1
module tb_des_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset      [2];
    logic       in_valid   [2];
    logic       in_decrypt [2];
    logic       abort      [2];
    logic       out_ready  [2];
    logic       in_ready   [2];
    logic       ld_en      [2];
    logic       ks_en      [2];
    logic       ks_dir     [2];
    logic [1:0] ks_amt     [2];
    logic       rnd_en     [2];
    logic [3:0] round      [2];
    logic       fp_en      [2];
    logic       busy       [2];
    logic       out_valid  [2];

    int total = 0;
    int bad   = 0;

    des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_LAT(2)) dut0 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_decrypt(in_decrypt[0]), .abort(abort[0]), .ld_en(ld_en[0]), .ks_en(ks_en[0]),
        .ks_dir(ks_dir[0]), .ks_amt(ks_amt[0]), .rnd_en(rnd_en[0]), .round(round[0]),
        .fp_en(fp_en[0]), .busy(busy[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_LAT(1)) dut1 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_decrypt(in_decrypt[1]), .abort(abort[1]), .ld_en(ld_en[1]), .ks_en(ks_en[1]),
        .ks_dir(ks_dir[1]), .ks_amt(ks_amt[1]), .rnd_en(rnd_en[1]), .round(round[1]),
        .fp_en(fp_en[1]), .busy(busy[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    // DES schedule: single-bit rotates in rounds 1,2,9,16, two bits elsewhere; decrypt skips round 1.
    function automatic logic [1:0] ref_amt(input int r, input bit dec);
        if (dec && r == 0) return 2'd0;
        if (r == 0 || r == 1 || r == 8 || r == 15) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [13:0] obs_vec(input int d, input bit mask_round);
        return {in_ready[d], ld_en[d], ks_en[d], ks_en[d] ? ks_amt[d] : 2'd0,
                ks_en[d] ? ks_dir[d] : 1'b0, rnd_en[d], mask_round ? 4'd0 : round[d],
                fp_en[d], busy[d], out_valid[d]};
    endfunction

    // t counts cycles from the accept cycle (t=0).
    function automatic logic [13:0] exp_vec(input int rl, input int t, input bit dec);
        int  n;
        bit  in_rnd;
        bit  ks;
        bit  rr;
        int  r;
        n      = 16 * rl;
        in_rnd = (t >= 1) && (t <= n);
        ks     = in_rnd && ((t - 1) % rl == 0);
        rr     = in_rnd && (t % rl == 0);
        r      = in_rnd ? (t - 1) / rl : 0;
        return {t == 0, t == 0, ks, ks ? ref_amt(r, dec) : 2'd0, ks ? dec : 1'b0, rr,
                4'(r), t == n + 1, in_rnd || (t == n + 1), t >= n + 2};
    endfunction

    logic [13:0] idle_vec;
    initial idle_vec = 14'b10_0000_0000_0000;

    task automatic drive_quiet(input int d);
        in_valid[d]   = 1'b0;
        in_decrypt[d] = 1'b0;
        abort[d]      = 1'b0;
        out_ready[d]  = 1'b0;
        reset[d]      = 1'b0;
    endtask

    task automatic run_block(input int d, input bit dec, input int hold, input int stop_t,
                             input bit stop_rst, output int ks_sum, output int ks_n,
                             output int rn_n);
        int rl;
        int n;
        logic [13:0] o;
        logic [13:0] e;
        rl     = (d == 0) ? 2 : 1;
        n      = 16 * rl;
        ks_sum = 0;
        ks_n   = 0;
        rn_n   = 0;
        for (int t = 0; t <= n + 1; t++) begin
            @(posedge clk); #1;
            in_valid[d]   = (t == 0) ? 1'b1 : 1'($urandom);
            in_decrypt[d] = (t == 0) ? dec : 1'($urandom);
            out_ready[d]  = 1'($urandom);
            abort[d]      = (t == stop_t) && !stop_rst;
            reset[d]      = (t == stop_t) && stop_rst;
            @(negedge clk);
            if (t == stop_t) return;
            o = obs_vec(d, !((t >= 1) && (t <= n)));
            e = exp_vec(rl, t, dec);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL seq d%0d dec=%0d t=%0d got=%b want=%b", d, dec, t, o, e);
            end
            if (ks_en[d]) begin
                ks_n++;
                ks_sum += int'(ks_amt[d]);
            end
            if (rnd_en[d]) rn_n++;
        end
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            in_valid[d]   = 1'($urandom);
            in_decrypt[d] = 1'($urandom);
            out_ready[d]  = (h == hold);
            @(negedge clk);
            o = obs_vec(d, 1'b1);
            e = exp_vec(rl, n + 2 + h, dec);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL done_hold d%0d h=%0d got=%b want=%b", d, h, o, e);
            end
        end
        @(posedge clk); #1;
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'($urandom);
        @(negedge clk);
        o = obs_vec(d, 1'b1);
        total++;
        if (o !== idle_vec) begin
            bad++;
            $display("FAIL back_to_idle d%0d got=%b want=%b", d, o, idle_vec);
        end
    endtask

    task automatic test_reset();
        logic [13:0] o;
        for (int d = 0; d < 2; d++) begin
            drive_quiet(d);
            reset[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) reset[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = obs_vec(d, 1'b0);
            total++;
            if (o !== idle_vec) begin
                bad++;
                $display("FAIL reset_state d%0d got=%b want=%b", d, o, idle_vec);
            end
        end
    endtask

    task automatic test_mode(input int d, input bit dec, input int hold);
        int s, kn, rn, want_sum;
        run_block(d, dec, hold, -1, 1'b0, s, kn, rn);
        want_sum = dec ? 27 : 28;
        total++;
        if (kn !== 16 || rn !== 16 || s !== want_sum) begin
            bad++;
            $display("FAIL pulse_counts d%0d dec=%0d got ks=%0d rnd=%0d sum=%0d want 16 16 %0d",
                     d, dec, kn, rn, s, want_sum);
        end
    endtask

    task automatic test_abort();
        int s, kn, rn;
        // round 7 with lat_cnt 1 is t=16 at two cycles per round
        run_block(0, 1'($urandom), 0, 16, 1'b0, s, kn, rn);
        test_mode(0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int s, kn, rn;
        logic [13:0] o;
        run_block(0, 1'b1, 0, 25, 1'b1, s, kn, rn);
        @(posedge clk); #1;
        reset[0]    = 1'b0;
        in_valid[0] = 1'b1;
        abort[0]    = 1'b1;
        @(negedge clk);
        o = obs_vec(0, 1'b0);
        total++;
        if (o !== idle_vec) begin
            bad++;
            $display("FAIL reset_mid_abort_idle got=%b want=%b", o, idle_vec);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        abort[0]    = 1'b0;
        @(negedge clk);
        o = obs_vec(0, 1'b0);
        total++;
        if (o !== idle_vec) begin
            bad++;
            $display("FAIL abort_blocks_accept got=%b want=%b", o, idle_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_mode(int'($urandom_range(1, 0)), 1'($urandom), int'($urandom_range(4, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_mode(0, 1'b0, 0);
        test_mode(0, 1'b1, 0);
        test_mode(0, 1'b0, 10);
        test_abort();
        test_reset_mid();
        test_mode(1, 1'b0, 0);
        test_mode(1, 1'b1, 2);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
